// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: SEG bits per stage using 4-bit carry-lookahead groups,
// with operand skew and sum de-skew registers and a single global advance/stall.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov,
  output logic             z,
  output logic             n
);

  localparam int STAGES = (SEG > 0) ? WIDTH / SEG : 1;

  if (SEG < 4 || (WIDTH % SEG) != 0 || (SEG % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_param
    $error("cla_pipe_addsub: illegal WIDTH/SEG combination");
  end

  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still to be added enter this stage; the low SEG are consumed here.
    localparam int RW = WIDTH - k * SEG;

    logic [RW-1:0]        src_a, src_b;
    logic                 src_c, src_v;
    logic [SEG-1:0]       gen, prop, seg_sum;
    logic [SEG:0]         c;
    logic [(k+1)*SEG-1:0] nxt_acc;
    logic                 vld, cry;
    logic [(k+1)*SEG-1:0] acc;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_b   = b ^ {WIDTH{sub}};
      assign src_c   = ci ^ sub;
      assign src_v   = in_valid;
      assign nxt_acc = seg_sum;
    end else begin : g_next
      assign src_a   = g_stage[k-1].g_fwd.op_a;
      assign src_b   = g_stage[k-1].g_fwd.op_b;
      assign src_c   = g_stage[k-1].cry;
      assign src_v   = g_stage[k-1].vld;
      assign nxt_acc = {seg_sum, g_stage[k-1].acc};
    end

    assign gen  = src_a[SEG-1:0] & src_b[SEG-1:0];
    assign prop = src_a[SEG-1:0] ^ src_b[SEG-1:0];
    assign c[0] = src_c;

    // Lookahead inside each 4-bit group; group carries chain to the next group.
    for (genvar j = 0; j < SEG; j += 4) begin : g_grp
      assign c[j+1] = gen[j] | (prop[j] & c[j]);
      assign c[j+2] = gen[j+1] | (prop[j+1] & gen[j]) | (prop[j+1] & prop[j] & c[j]);
      assign c[j+3] = gen[j+2] | (prop[j+2] & gen[j+1]) | (prop[j+2] & prop[j+1] & gen[j])
                    | (prop[j+2] & prop[j+1] & prop[j] & c[j]);
      assign c[j+4] = gen[j+3] | (prop[j+3] & gen[j+2]) | (prop[j+3] & prop[j+2] & gen[j+1])
                    | (prop[j+3] & prop[j+2] & prop[j+1] & gen[j])
                    | (prop[j+3] & prop[j+2] & prop[j+1] & prop[j] & c[j]);
    end

    assign seg_sum = prop ^ c[SEG-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        cry <= 1'b0;
        acc <= '0;
      end else if (adv) begin
        vld <= src_v;
        cry <= c[SEG];
        acc <= nxt_acc;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [RW-SEG-1:0] op_a, op_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_a <= '0;
          op_b <= '0;
        end else if (adv) begin
          op_a <= src_a[RW-1:SEG];
          op_b <= src_b[RW-1:SEG];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ov <= 1'b0;
          z  <= 1'b0;
          n  <= 1'b0;
        end else if (adv) begin
          ov <= c[SEG] ^ c[SEG-1];
          z  <= (nxt_acc == '0);
          n  <= seg_sum[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld;
  assign s         = g_stage[STAGES-1].acc;
  assign co        = g_stage[STAGES-1].cry;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Self-checking bench for cla_pipe_addsub (WIDTH=32, SEG=8): directed corner cases,
// stall and reset scenarios, then randomized traffic against an arithmetic model.
module tb_cla_pipe_addsub;

  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, ci, sub, out_valid, out_ready;
  logic [31:0] a, b, s;
  logic        co, ov, z, n;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned stalls  = 0;

  typedef struct {
    logic [31:0] s;
    logic        co, ov, z, n;
    int unsigned cyc, stl;
  } exp_t;

  exp_t q[$];

  logic        held;
  logic [31:0] held_s;
  logic [3:0]  held_f;

  cla_pipe_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .co(co), .ov(ov), .z(z), .n(n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ia, ib, input logic ici, isub);
    exp_t        e;
    logic [31:0] bx;
    logic [32:0] full;
    bx   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bx} + 33'(ici ^ isub);
    e.s  = full[31:0];
    e.co = full[32];
    e.ov = (ia[31] == bx[31]) && (e.s[31] != ia[31]);
    e.z  = (e.s == 32'd0);
    e.n  = e.s[31];
    e.cyc = 0;
    e.stl = 0;
    return e;
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] ia, ib, input logic ici, isub,
                       input logic ior, irst, output logic accepted);
    exp_t e;
    accepted = 1'b0;
    @(negedge clk);
    rst = irst; in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = ior;
    #1;
    cyc++;
    if (irst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_s", s, 0);
      chk("rst_flags", {co, ov, z, n}, 0);
      q.delete();
      held = 1'b0;
      return;
    end
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (held) begin
      chk("stall_hold_s", s, held_s);
      chk("stall_hold_flags", {co, ov, z, n}, held_f);
    end
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        e = q[0];
        chk("s", s, e.s);
        chk("flags_co_ov_z_n", {co, ov, z, n}, {e.co, e.ov, e.z, e.n});
        if (out_ready) begin
          void'(q.pop_front());
          chk("latency", cyc - e.cyc, STAGES + (stalls - e.stl));
        end
      end
    end
    held = out_valid && !out_ready;
    if (held) begin
      held_s = s;
      held_f = {co, ov, z, n};
      stalls++;
    end
    if (iv && in_ready) begin
      e = model(ia, ib, ici, isub);
      e.cyc = cyc;
      e.stl = stalls;
      q.push_back(e);
      accepted = 1'b1;
    end
  endtask

  task automatic idle(input int unsigned cnt);
    logic acc;
    for (int unsigned i = 0; i < cnt; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic one_op(input logic [31:0] ia, ib, input logic ici, isub);
    logic acc;
    cycle(1'b1, ia, ib, ici, isub, 1'b1, 1'b0, acc);
    chk("directed_accept", acc, 1);
    idle(STAGES + 1);
    chk("directed_drained", q.size(), 0);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        acc;
    int unsigned issued;
    logic [31:0] ra [6];
    logic [31:0] rb [6];

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    held = 1'b0; held_s = '0; held_f = '0;

    cycle(1'b1, 32'h1234, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 32'h1234, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    idle(STAGES + 1);

    one_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    one_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    one_op(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1);
    one_op(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1);
    one_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    one_op(32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0);

    // Six back-to-back operations with a 3-cycle consumer stall once results appear.
    for (int i = 0; i < 6; i++) begin
      ra[i] = $urandom;
      rb[i] = $urandom;
    end
    issued = 0;
    for (int unsigned t = 0; t < 40 && (issued < 6 || q.size() != 0); t++) begin
      cycle(issued < 6, issued < 6 ? ra[issued] : '0, issued < 6 ? rb[issued] : '0,
            issued[0], issued[1], !(t >= 5 && t <= 7), 1'b0, acc);
      if (t >= 5 && t <= 7) chk("stall_in_ready", in_ready, 0);
      if (acc) issued++;
    end
    chk("b2b_issued", issued, 6);
    chk("b2b_drained", q.size(), 0);

    // Reset with two operations in flight; the next one must still take 4 cycles.
    cycle(1'b1, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'h0BAD_F00D, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 1'b1, 1'b0, acc);
    chk("post_reset_accept", acc, 1);
    for (int unsigned i = 0; i < STAGES - 1; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
      chk("post_reset_quiet", out_valid, 0);
    end
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("post_reset_result", out_valid, 1);
    idle(2);

    for (int unsigned t = 0; t < 400; t++) begin
      cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 7, 1'b0, acc);
    end

    for (int unsigned t = 0; t < 50 && q.size() != 0; t++) idle(1);
    chk("final_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
